// File: rtl/sram_mem_controller_if.sv
// rtl/sram_mem_controller_if.sv - load/store request bus between the pipeline and the SRAM controller
interface sram_mem_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - 32-bit load/store over a 16-bit async SRAM; optional last-read cache via SRAM_LAST_READ_CACHE_EN
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_mem_controller_if.slave bus,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    inout  tri   [15:0]          SRAM_DQ,
    output logic                 SRAM_WE_N
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic        ready_c;
    logic        req;
    logic        hit;
    logic        start;
    logic        phase_last;
    logic        in_phase;
    logic [31:0] req_off;
    logic [29:0] req_word;
    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic        store_q;
    logic [31:0] rdata_q;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_bits;

    assign req        = bus.rd_en | bus.wr_en;
    assign req_off    = bus.addr - BASE_ADDR;
    assign req_word   = req_off[31:2];
    assign phase_last = (cnt == LAST_CNT);
    assign in_phase   = (state == S_LO) || (state == S_HI);
    // An accepted request leaves IDLE; a cache hit is answered without touching the SRAM.
    assign start      = (state == S_IDLE) && req && !hit;
    assign unused_bits = ^{req_off[1:0], word_q};

`ifdef SRAM_LAST_READ_CACHE_EN
    logic        cache_valid;
    logic [29:0] cache_tag;
    logic [31:0] cache_data;

    // A store request always wins, so only a pure load can hit.
    assign hit = (state == S_IDLE) && bus.rd_en && !bus.wr_en
                 && cache_valid && (cache_tag == req_word);
    assign bus.rdata = hit ? cache_data : rdata_q;

    // Fill on every completed SRAM load; keep the entry coherent with stores to the same word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (state == S_DONE) begin
            if (!store_q) begin
                cache_valid <= 1'b1;
                cache_tag   <= word_q;
                cache_data  <= rdata_q;
            end else if (cache_valid && (cache_tag == word_q)) begin
                cache_data  <= wdata_q;
            end
        end
    end
`else
    assign hit       = 1'b0;
    assign bus.rdata = rdata_q;
`endif

    assign bus.ready = ready_c;

    // State register and per-phase cycle counter; the counter restarts on every phase entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if ((state_nx == state) && in_phase)
                cnt <= cnt + 4'd1;
            else
                cnt <= '0;
        end
    end

    // Next-state and ready decode.
    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = !req || hit;
                if (start)
                    state_nx = S_LO;
            end
            S_LO: begin
                if (phase_last)
                    state_nx = S_HI;
            end
            S_HI: begin
                if (phase_last)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                ready_c  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Latch the request in the accepting IDLE cycle; the pipeline may drop or change it afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
        end else if (start) begin
            word_q  <= req_word;
            wdata_q <= bus.wdata;
            store_q <= bus.wr_en;
        end
    end

    // SRAM address is registered so it is stable for the whole phase and holds while idle.
    always_ff @(posedge clk) begin
        if (!rst)
            SRAM_ADDR <= '0;
        else if (start)
            SRAM_ADDR <= {req_word[SRAM_AW-2:0], 1'b0};
        else if ((state == S_LO) && phase_last)
            SRAM_ADDR <= {word_q[SRAM_AW-2:0], 1'b1};
    end

    // Load data is sampled at the end of each phase, after the SRAM access time has elapsed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (!store_q && phase_last) begin
            if (state == S_LO)
                rdata_q[15:0] <= SRAM_DQ;
            else if (state == S_HI)
                rdata_q[31:16] <= SRAM_DQ;
        end
    end

    // WE_N rises in the last cycle of each store phase while address and data are still held.
    assign dq_oe     = store_q && in_phase;
    assign dq_out    = (state == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_WE_N = !(dq_oe && !phase_last);

endmodule
